pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage. It is the successor of the simple next-PC register.
- Adds a configurable reset vector and width, a valid/ready fetch handshake, and two-level redirect priority (trap over jump).
- A redirect that arrives while a fetch is stalled is held in a pending register until that fetch is accepted.
- Supports debug halt/resume and flags misaligned redirect targets.
- Sits between the execute/trap logic (redirect sources) and the instruction-memory request port.

Parameters:
- XLEN, 32, width of PC and redirect addresses.
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- STEP, 4, sequential increment in bytes; also the alignment unit (must be a power of 2, at least 2).

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- jump_en  input  1  branch/jump redirect request, single-cycle pulse
- jump_addr  input  XLEN  jump target
- trap_en  input  1  trap/exception redirect request, higher priority than jump
- trap_addr  input  XLEN  trap vector
- halt_req  input  1  level; request fetch halt
- resume_req  input  1  pulse; leave HALT
- fetch_ready  input  1  instruction memory accepts the request
- fetch_valid  output  1  request valid
- pc  output  XLEN  fetch address, stable while fetch_valid && !fetch_ready
- halted  output  1  high in HALT state
- misalign_err  output  1  one-cycle pulse: accepted redirect target was not STEP-aligned

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low: assertion takes effect immediately, deassertion is sampled on the clk edge.
- Reset values: pc=RESET_ADDR, fetch_valid=0, halted=0, misalign_err=0, state=BOOT, pend_valid=0.
- State machine (BOOT, RUN, HALT):
  - BOOT: one cycle, then RUN. fetch_valid stays 0 in BOOT. First request is pc=RESET_ADDR, valid in the 2nd cycle after reset release.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, halted=1.
- Handshake:
  - Transfer occurs when fetch_valid && fetch_ready.
  - pc and fetch_valid must not change while valid && !ready, except on reset.
- Next-PC on transfer, in priority order:
  1. trap_en this cycle → trap_addr
  2. jump_en this cycle → jump_addr
  3. pend_valid → pend_addr (pending register is then cleared)
  4. otherwise → pc + STEP, modulo 2^XLEN (all-ones - STEP+1 wraps to 0)
- Redirect with no transfer in RUN (stalled):
  - Latch the target into pend_addr and set pend_valid.
  - A pending trap is not overwritten by a later jump. A later trap overwrites a pending jump. A later jump overwrites a pending jump.
- Redirect in HALT or BOOT: pc is loaded directly on the next edge, no pending. Trap still wins over jump.
- Alignment:
  - Any redirect target has its low log2(STEP) bits forced to 0 before use.
  - misalign_err pulses in the cycle after the target is captured, i.e. loaded or latched into pending.
- Halt:
  - halt_req seen in RUN: stay in RUN until the current request transfers (or immediately if none is outstanding), then go to HALT with pc already advanced.
  - resume_req in HALT → RUN next cycle. If halt_req is still high, resume_req is ignored.
  - A pending redirect survives HALT and is applied on entry to HALT.
- Simultaneous trap_en and jump_en: the trap is used and the jump is dropped.
- Reset mid-stall or mid-halt: all state, including the pending register, returns to reset values.

Decomposition:
- Shared package, e.g. core_pkg:
  - XLEN default.
  - RESET_ADDR default.
  - State encoding constants: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
- One natural sub-module: pc_redirect_buf. It holds the pending register, the overwrite-priority rule and target alignment, and outputs pend_valid/pend_addr/misalign flag.
- The FSM and next-PC mux live in pc_gen.

Test Plan:
- Reset release, fetch_ready=1 constant → fetch_valid rises in cycle 2; pc sequence 0x0, 0x4, 0x8, 0xC.
- Stall: fetch_ready=0 for 3 cycles at pc=0x8, jump_en pulse to 0x100 during the stall → pc holds 0x8; after ready, pc=0x100, then 0x104.
- Same cycle trap_en (0x80) and jump_en (0x200) with ready=1 → pc=0x80. Repeat while stalled, trap first then jump → pending stays 0x80.
- jump_addr=0x102 with STEP=4 → pc=0x100, misalign_err high for exactly one cycle. With STEP=2 → pc=0x102, no error.
- halt_req while stalled at 0x10 → stays valid until ready, then halted=1, fetch_valid=0, pc=0x14. jump to 0x40 in HALT → pc=0x40. resume_req → fetch 0x40.
- XLEN=32, pc=0xFFFF_FFFC, ready=1 → next pc=0x0. Assert rstn=0 mid-stall → pc=RESET_ADDR immediately, pending cleared.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared defaults and state encoding for the fetch-stage PC generator.
// No logic; constants and types only.
// Imported by pc_gen and pc_redirect_buf.
package pc_gen_pkg;

  localparam int          XLEN_DEF       = 32;
  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
  localparam int          STEP_DEF       = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Redirect target alignment, trap-over-jump select and the pending-redirect register.
// Pending register and misalign flag update one edge after capture.
// Latches a redirect only while the fetch request is stalled; cleared on transfer.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int STEP = STEP_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_trap_en,
  input  logic [XLEN-1:0] i_trap_addr,
  input  logic            i_jump_en,
  input  logic [XLEN-1:0] i_jump_addr,
  input  logic            i_load,      // target is consumed directly into pc this edge
  input  logic            i_stall,     // request outstanding and not accepted
  input  logic            i_clear,     // request transferred: pending is used or superseded
  output logic [XLEN-1:0] o_tgt_addr,
  output logic            o_pend_valid,
  output logic [XLEN-1:0] o_pend_addr,
  output logic            o_misalign
);

  localparam int SHIFT = $clog2(STEP);

  logic [XLEN-1:0] w_raw;
  logic            w_redir;
  logic            w_odd;
  logic            w_take_pend;
  logic            w_capture;

  logic            r_pend_valid;
  logic            r_pend_trap;
  logic [XLEN-1:0] r_pend_addr;
  logic            r_misalign;

  assign w_raw      = i_trap_en ? i_trap_addr : i_jump_addr;
  assign w_redir    = i_trap_en || i_jump_en;
  assign w_odd      = |w_raw[SHIFT-1:0];
  assign o_tgt_addr = {w_raw[XLEN-1:SHIFT], {SHIFT{1'b0}}};

  // A held trap may only be replaced by another trap; a held jump by anything.
  assign w_take_pend = i_stall && w_redir &&
                       (i_trap_en || !r_pend_valid || !r_pend_trap);
  assign w_capture   = w_redir && (i_load || w_take_pend);

  // Pending register update and one-cycle misalign pulse on every captured target.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_pend_addr  <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= w_capture && w_odd;
      if (i_clear) begin
        r_pend_valid <= 1'b0;
        r_pend_trap  <= 1'b0;
      end else if (w_take_pend) begin
        r_pend_valid <= 1'b1;
        r_pend_trap  <= i_trap_en;
        r_pend_addr  <= o_tgt_addr;
      end
    end
  end

  assign o_pend_valid = r_pend_valid;
  assign o_pend_addr  = r_pend_addr;
  assign o_misalign   = r_misalign;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with redirect priority, debug halt and misalign flag.
// First request valid two cycles after reset release; next pc one edge after each transfer.
// pc/fetch_valid hold while fetch_ready is low; redirects arriving then are held pending.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(RESET_ADDR_DEF),
  parameter int              STEP       = STEP_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            misalign_err
);

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_halted;

  logic            w_in_run;
  logic            w_xfer;
  logic            w_redir;
  logic            w_load;
  logic            w_stall;
  logic [XLEN-1:0] w_tgt;
  logic            w_pend_valid;
  logic [XLEN-1:0] w_pend_addr;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misalign;

  assign w_in_run = (r_state == ST_RUN);
  assign w_xfer   = r_valid && fetch_ready;
  assign w_redir  = trap_en || jump_en;
  // Outside RUN nothing is outstanding, so a redirect goes straight into pc.
  assign w_load   = w_xfer || !w_in_run;
  assign w_stall  = w_in_run && !fetch_ready;

  pc_redirect_buf #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_redirect_buf (
    .clk          (clk),
    .rstn         (rstn),
    .i_trap_en    (trap_en),
    .i_trap_addr  (trap_addr),
    .i_jump_en    (jump_en),
    .i_jump_addr  (jump_addr),
    .i_load       (w_load),
    .i_stall      (w_stall),
    .i_clear      (w_xfer),
    .o_tgt_addr   (w_tgt),
    .o_pend_valid (w_pend_valid),
    .o_pend_addr  (w_pend_addr),
    .o_misalign   (w_misalign)
  );

  // Next fetch address on transfer: live redirect, then pending, then sequential.
  always_comb begin
    w_next_pc = r_pc + XLEN'(STEP);
    if (w_redir) begin
      w_next_pc = w_tgt;
    end else if (w_pend_valid) begin
      w_next_pc = w_pend_addr;
    end
  end

  // BOOT/RUN/HALT sequencing with registered pc, valid and halted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_ADDR;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
          r_valid <= 1'b1;
          if (w_redir) r_pc <= w_tgt;
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_pc <= w_next_pc;
            if (halt_req) begin
              r_state  <= ST_HALT;
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (w_redir) r_pc <= w_tgt;
          if (resume_req && !halt_req) begin
            r_state  <= ST_RUN;
            r_valid  <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_BOOT;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid  = r_valid;
  assign pc           = r_pc;
  assign halted       = r_halted;
  assign misalign_err = w_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: STEP=4 and STEP=2 instances share one stimulus stream.
// Driver computes expected outputs from a behavioural model and queues them;
// a monitor on the falling edge pops and compares.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        jump_en = 1'b0, trap_en = 1'b0, halt_req = 1'b0, resume_req = 1'b0;
  logic        fetch_ready = 1'b0;
  logic [31:0] jump_addr = '0, trap_addr = '0;

  logic        fv0, h0, me0, fv1, h1, me1;
  logic [31:0] pc0, pc1;

  always #5 clk = ~clk;

  pc_gen u_dut0 (
    .clk(clk), .rstn(rstn), .jump_en(jump_en), .jump_addr(jump_addr),
    .trap_en(trap_en), .trap_addr(trap_addr), .halt_req(halt_req),
    .resume_req(resume_req), .fetch_ready(fetch_ready), .fetch_valid(fv0),
    .pc(pc0), .halted(h0), .misalign_err(me0)
  );

  pc_gen #(.STEP(2)) u_dut1 (
    .clk(clk), .rstn(rstn), .jump_en(jump_en), .jump_addr(jump_addr),
    .trap_en(trap_en), .trap_addr(trap_addr), .halt_req(halt_req),
    .resume_req(resume_req), .fetch_ready(fetch_ready), .fetch_valid(fv1),
    .pc(pc1), .halted(h1), .misalign_err(me1)
  );

  int errors = 0;
  int checks = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic        h;
    logic        m;
    logic [31:0] pc;
  } st_t;

  st_t         q_st0[$], q_st1[$];
  logic [31:0] q_pc0[$], q_pc1[$];

  // Behavioural model: one entry per instance.
  int unsigned m_step[2] = '{4, 2};
  logic [31:0] m_pc[2]   = '{32'h0, 32'h0};
  logic [31:0] m_pa[2]   = '{32'h0, 32'h0};
  bit          m_boot[2] = '{1'b1, 1'b1};
  bit          m_halt[2] = '{1'b0, 1'b0};
  bit          m_pv[2]   = '{1'b0, 1'b0};
  bit          m_ptrap[2] = '{1'b0, 1'b0};
  bit          m_mis[2]  = '{1'b0, 1'b0};

  task automatic model_cycle();
    for (int k = 0; k < 2; k++) begin
      st_t         e;
      logic [31:0] raw, al;
      bit          odd, redir, nmis;
      if (!rstn) begin
        m_pc[k] = 32'h0; m_boot[k] = 1; m_halt[k] = 0;
        m_pv[k] = 0; m_ptrap[k] = 0; m_mis[k] = 0;
      end
      e.v  = rstn && !m_boot[k] && !m_halt[k];
      e.h  = m_halt[k];
      e.m  = m_mis[k];
      e.pc = m_pc[k];
      if (k == 0) q_st0.push_back(e); else q_st1.push_back(e);
      if (e.v && fetch_ready) begin
        if (k == 0) q_pc0.push_back(m_pc[k]); else q_pc1.push_back(m_pc[k]);
      end
      if (rstn) begin
        raw   = trap_en ? trap_addr : jump_addr;
        al    = raw - (raw % m_step[k]);
        odd   = (raw % m_step[k]) != 0;
        redir = trap_en || jump_en;
        nmis  = 0;
        if (m_boot[k]) begin
          m_boot[k] = 0;
          if (redir) begin m_pc[k] = al; nmis = odd; end
        end else if (m_halt[k]) begin
          if (redir) begin m_pc[k] = al; nmis = odd; end
          if (resume_req && !halt_req) m_halt[k] = 0;
        end else if (fetch_ready) begin
          if (redir) begin m_pc[k] = al; nmis = odd; end
          else if (m_pv[k]) m_pc[k] = m_pa[k];
          else m_pc[k] = m_pc[k] + m_step[k];
          m_pv[k] = 0;
          if (halt_req) m_halt[k] = 1;
        end else if (redir && !(m_pv[k] && m_ptrap[k] && !trap_en)) begin
          m_pv[k] = 1; m_ptrap[k] = trap_en; m_pa[k] = al; nmis = odd;
        end
        m_mis[k] = nmis;
      end
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), record expectations, advance.
  task automatic cyc(input bit rn, input bit rdy, input bit je, input logic [31:0] ja,
                     input bit te, input logic [31:0] ta, input bit hr, input bit rr);
    rstn = rn; fetch_ready = rdy; jump_en = je; jump_addr = ja;
    trap_en = te; trap_addr = ta; halt_req = hr; resume_req = rr;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle status and in-order transfer addresses.
  always @(negedge clk) begin
    st_t e;
    if (q_st0.size() > 0) begin
      e = q_st0.pop_front();
      cmp("u0 fetch_valid", fv0, e.v); cmp("u0 pc", pc0, e.pc);
      cmp("u0 halted", h0, e.h);       cmp("u0 misalign_err", me0, e.m);
    end
    if (q_st1.size() > 0) begin
      e = q_st1.pop_front();
      cmp("u1 fetch_valid", fv1, e.v); cmp("u1 pc", pc1, e.pc);
      cmp("u1 halted", h1, e.h);       cmp("u1 misalign_err", me1, e.m);
    end
    if (fv0 && fetch_ready) begin
      if (q_pc0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0 unexpected transfer: pc 0x%08h, none expected", pc0);
      end else cmp("u0 transfer pc", pc0, q_pc0.pop_front());
    end
    if (fv1 && fetch_ready) begin
      if (q_pc1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1 unexpected transfer: pc 0x%08h, none expected", pc1);
      end else cmp("u1 transfer pc", pc1, q_pc1.pop_front());
    end
  end

  initial begin
    bit hold_halt;
    hold_halt = 0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cmp("reset pc", pc0, 32'h0); cmp("reset valid", fv0, 0);
    cmp("reset halted", h0, 0);  cmp("reset misalign", me0, 0);

    // Boot then sequential fetch.
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cmp("first valid", fv0, 1); cmp("first pc", pc0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("seq pc 4", pc0, 32'h4);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("seq pc 8", pc0, 32'h8);

    // Stall with jump pending.
    cyc(1, 0, 1, 32'h100, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cmp("stall hold pc", pc0, 32'h8); cmp("stall hold valid", fv0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("pending jump pc", pc0, 32'h100);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("after jump pc", pc0, 32'h104);

    // Trap beats jump, live and pending.
    cyc(1, 1, 1, 32'h200, 1, 32'h80, 0, 0); cmp("trap over jump", pc0, 32'h80);
    cyc(1, 0, 0, 0, 1, 32'h80, 0, 0);
    cyc(1, 0, 1, 32'h300, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("pending trap kept", pc0, 32'h80);

    // Misaligned target: STEP=4 rounds and flags, STEP=2 takes it clean.
    cyc(1, 1, 1, 32'h102, 0, 0, 0, 0);
    cmp("misalign pc step4", pc0, 32'h100); cmp("misalign flag step4", me0, 1);
    cmp("pc step2", pc1, 32'h102);          cmp("no misalign step2", me1, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("misalign one cycle", me0, 0);

    // Halt while stalled, redirect in HALT, resume.
    cyc(1, 1, 1, 32'h10, 0, 0, 0, 0); cmp("jump to 0x10", pc0, 32'h10);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cmp("halt waits pc", pc0, 32'h10); cmp("halt waits valid", fv0, 1); cmp("not yet halted", h0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 0);
    cmp("halted", h0, 1); cmp("halt valid low", fv0, 0); cmp("halt pc advanced", pc0, 32'h14);
    cyc(1, 0, 1, 32'h40, 0, 0, 0, 0); cmp("jump in halt", pc0, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cmp("resume valid", fv0, 1); cmp("resume pc", pc0, 32'h40); cmp("resume halted", h0, 0);

    // Address wrap.
    cyc(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); cmp("top pc", pc0, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("wrap pc", pc0, 32'h0);

    // Reset mid-stall discards pending.
    cyc(1, 0, 1, 32'h500, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0); cmp("midstall reset pc", pc0, 32'h0); cmp("midstall reset valid", fv0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("post reset pc", pc0, 32'h0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); cmp("pending cleared", pc0, 32'h4);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) hold_halt = !hold_halt;
      cyc($urandom_range(0, 599) != 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 19) == 0, $urandom,
          hold_halt, $urandom_range(0, 7) == 0);
    end
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    cmp("u0 leftover transfers", q_pc0.size(), 0);
    cmp("u1 leftover transfers", q_pc1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
